tdpram_singleclk_bwe: RTL and testbench

//  - Single-clock true dual-port RAM with per-byte write enables, read enables and read-valid flags.
//  - Per-port read-during-write mode and optional output register.
//  - Defined cross-port collision handling: A-priority writes and optional cross-port write forwarding.
//  - Generic storage for FIFOs, coefficient and sample buffers where both ports share one clock.

---
 rtl/tdpram_singleclk_bwe.sv | 213 +++++++++++++++++++++
 tb/tb_tdpram_singleclk_bwe.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/tdpram_singleclk_bwe.sv
// -----------------------------------------------------------------------------
// tdpram_singleclk_bwe
//   Single-clock true dual-port RAM with per-byte write enables, read enables
//   and read-valid flags. Each port has its own read-during-write mode and an
//   optional output register. Same-address dual writes are merged per lane.
//   When both ports write the same lane, port A wins. Optional cross-port
//   forwarding returns the other port's same-cycle write data.
//
// Parameters
//   DATA_WIDTH, BYTE_WIDTH  word width and write-lane width (NB_LANES lanes)
//   DEPTH, ADDR_WIDTH       number of words; DEPTH need not be a power of 2
//   WRITE_MODE_A/B          "READ_FIRST" | "WRITE_FIRST" | "NO_CHANGE"
//   OUTPUT_REG_A/B          1 adds one output register stage on that port
//   CROSS_FWD               1 forwards the other port's same-address write data
//   RAM_INIT_FILE           init source name; contents start uninitialised
//
// Ports
//   CLK_I, RST_N_I          clock (rising edge), async active-low reset
//   ENx_I, WENx_I           port access enable, per-lane write enable
//   ADDRx_I, DINx_I         word address, write data
//   DOUTx_O, VALIDx_O       read data, one-cycle "new read data" flag
//   COLL_O                  one-cycle pulse the cycle after a collision
//   COLL_CNT_O              saturating collision count; only present when
//                           the TDPRAM_COLL_CNT_EN macro is defined
// -----------------------------------------------------------------------------
module tdpram_singleclk_bwe #(
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned BYTE_WIDTH    = 8,
    parameter int unsigned DEPTH         = 256,
    parameter int unsigned ADDR_WIDTH    = (DEPTH < 2) ? 1 : $clog2(DEPTH),
    parameter string       WRITE_MODE_A  = "READ_FIRST",
    parameter string       WRITE_MODE_B  = "READ_FIRST",
    parameter bit          OUTPUT_REG_A  = 1'b0,
    parameter bit          OUTPUT_REG_B  = 1'b0,
    parameter bit          CROSS_FWD     = 1'b0,
    parameter string       RAM_INIT_FILE = "RAMINIT.hex",
    localparam int unsigned NB_LANES     = DATA_WIDTH / BYTE_WIDTH
) (
    input  logic                  CLK_I,
    input  logic                  RST_N_I,
    input  logic                  ENA_I,
    input  logic [NB_LANES-1:0]   WENA_I,
    input  logic [ADDR_WIDTH-1:0] ADDRA_I,
    input  logic [DATA_WIDTH-1:0] DINA_I,
    output logic [DATA_WIDTH-1:0] DOUTA_O,
    output logic                  VALIDA_O,
    input  logic                  ENB_I,
    input  logic [NB_LANES-1:0]   WENB_I,
    input  logic [ADDR_WIDTH-1:0] ADDRB_I,
    input  logic [DATA_WIDTH-1:0] DINB_I,
    output logic [DATA_WIDTH-1:0] DOUTB_O,
    output logic                  VALIDB_O,
    output logic                  COLL_O
`ifdef TDPRAM_COLL_CNT_EN
    ,
    output logic [15:0]           COLL_CNT_O
`endif
);

    localparam bit WrFirstA  = (WRITE_MODE_A == "WRITE_FIRST");
    localparam bit WrFirstB  = (WRITE_MODE_B == "WRITE_FIRST");
    localparam bit NoChangeA = (WRITE_MODE_A == "NO_CHANGE");
    localparam bit NoChangeB = (WRITE_MODE_B == "NO_CHANGE");

    // Replace the lanes of base selected by sel with the matching lanes of alt.
    function automatic logic [DATA_WIDTH-1:0] lane_mux(input logic [DATA_WIDTH-1:0] base,
                                                       input logic [NB_LANES-1:0]   sel,
                                                       input logic [DATA_WIDTH-1:0] alt);
        logic [DATA_WIDTH-1:0] res;
        res = base;
        for (int i = 0; i < int'(NB_LANES); i++) begin
            if (sel[i]) begin
                res[i*BYTE_WIDTH +: BYTE_WIDTH] = alt[i*BYTE_WIDTH +: BYTE_WIDTH];
            end
        end
        return res;
    endfunction

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  a_in_range, b_in_range, same_addr;
    logic [NB_LANES-1:0]   we_a, we_b;
    logic [NB_LANES-1:0]   fwd_to_a, fwd_to_b, own_a, own_b;
    logic [DATA_WIDTH-1:0] raw_a, raw_b, rdata_a, rdata_b;
    logic                  rd_en_a, rd_en_b;

    always_comb begin
        a_in_range = 32'(ADDRA_I) < DEPTH;
        b_in_range = 32'(ADDRB_I) < DEPTH;
        same_addr  = ADDRA_I == ADDRB_I;
        we_a       = (ENA_I && a_in_range) ? WENA_I : '0;
        we_b       = (ENB_I && b_in_range) ? WENB_I : '0;
        // Out-of-range reads return zero; forwarding only from in-range writes.
        raw_a      = a_in_range ? mem[ADDRA_I] : '0;
        raw_b      = b_in_range ? mem[ADDRB_I] : '0;
        fwd_to_a   = (CROSS_FWD && same_addr) ? we_b : '0;
        fwd_to_b   = (CROSS_FWD && same_addr) ? we_a : '0;
        own_a      = WrFirstA ? we_a : '0;
        own_b      = WrFirstB ? we_b : '0;
        // Own-port write-first data has priority over cross-port forwarding.
        rdata_a    = lane_mux(lane_mux(raw_a, fwd_to_a, DINB_I), own_a, DINA_I);
        rdata_b    = lane_mux(lane_mux(raw_b, fwd_to_b, DINA_I), own_b, DINB_I);
        rd_en_a    = ENA_I && !(NoChangeA && (|WENA_I));
        rd_en_b    = ENB_I && !(NoChangeB && (|WENB_I));
    end

    // Storage: B lanes are assigned first so a same-lane A write overrides.
    always_ff @(posedge CLK_I) begin
        if (RST_N_I) begin
            for (int i = 0; i < int'(NB_LANES); i++) begin
                if (we_b[i]) begin
                    mem[ADDRB_I][i*BYTE_WIDTH +: BYTE_WIDTH] <= DINB_I[i*BYTE_WIDTH +: BYTE_WIDTH];
                end
                if (we_a[i]) begin
                    mem[ADDRA_I][i*BYTE_WIDTH +: BYTE_WIDTH] <= DINA_I[i*BYTE_WIDTH +: BYTE_WIDTH];
                end
            end
        end
    end

    // First read stage and collision flag.
    logic [DATA_WIDTH-1:0] douta_s1_d, douta_s1_q, doutb_s1_d, doutb_s1_q;
    logic                  valida_s1_d, valida_s1_q, validb_s1_d, validb_s1_q;
    logic                  coll_d, coll_q;

    always_comb begin
        douta_s1_d  = douta_s1_q;
        doutb_s1_d  = doutb_s1_q;
        valida_s1_d = rd_en_a;
        validb_s1_d = rd_en_b;
        if (rd_en_a) douta_s1_d = rdata_a;
        if (rd_en_b) doutb_s1_d = rdata_b;
        coll_d = ENA_I && ENB_I && same_addr && ((|WENA_I) || (|WENB_I));
    end

    always_ff @(posedge CLK_I or negedge RST_N_I) begin
        if (!RST_N_I) begin
            douta_s1_q  <= '0;
            doutb_s1_q  <= '0;
            valida_s1_q <= 1'b0;
            validb_s1_q <= 1'b0;
            coll_q      <= 1'b0;
        end else begin
            douta_s1_q  <= douta_s1_d;
            doutb_s1_q  <= doutb_s1_d;
            valida_s1_q <= valida_s1_d;
            validb_s1_q <= validb_s1_d;
            coll_q      <= coll_d;
        end
    end

    assign COLL_O = coll_q;

    // Optional output register; stage 1 already holds between reads so a plain copy suffices.
    generate
        if (OUTPUT_REG_A) begin : g_oreg_a
            logic [DATA_WIDTH-1:0] douta_s2_q;
            logic                  valida_s2_q;
            always_ff @(posedge CLK_I or negedge RST_N_I) begin
                if (!RST_N_I) begin
                    douta_s2_q  <= '0;
                    valida_s2_q <= 1'b0;
                end else begin
                    douta_s2_q  <= douta_s1_q;
                    valida_s2_q <= valida_s1_q;
                end
            end
            assign DOUTA_O  = douta_s2_q;
            assign VALIDA_O = valida_s2_q;
        end else begin : g_nreg_a
            assign DOUTA_O  = douta_s1_q;
            assign VALIDA_O = valida_s1_q;
        end

        if (OUTPUT_REG_B) begin : g_oreg_b
            logic [DATA_WIDTH-1:0] doutb_s2_q;
            logic                  validb_s2_q;
            always_ff @(posedge CLK_I or negedge RST_N_I) begin
                if (!RST_N_I) begin
                    doutb_s2_q  <= '0;
                    validb_s2_q <= 1'b0;
                end else begin
                    doutb_s2_q  <= doutb_s1_q;
                    validb_s2_q <= validb_s1_q;
                end
            end
            assign DOUTB_O  = doutb_s2_q;
            assign VALIDB_O = validb_s2_q;
        end else begin : g_nreg_b
            assign DOUTB_O  = doutb_s1_q;
            assign VALIDB_O = validb_s1_q;
        end
    endgenerate

`ifdef TDPRAM_COLL_CNT_EN
    logic [15:0] coll_cnt_d, coll_cnt_q;

    always_comb begin
        coll_cnt_d = coll_cnt_q;
        if (coll_q && (coll_cnt_q != 16'hFFFF)) coll_cnt_d = coll_cnt_q + 16'd1;
    end

    always_ff @(posedge CLK_I or negedge RST_N_I) begin
        if (!RST_N_I) coll_cnt_q <= '0;
        else          coll_cnt_q <= coll_cnt_d;
    end

    assign COLL_CNT_O = coll_cnt_q;
`else
    // No collision counter in this build.
`endif

endmodule

// File: tb/tb_tdpram_singleclk_bwe.sv
// Directed bench for tdpram_singleclk_bwe using two instances:
//   u0: DEPTH=100, A NO_CHANGE, B READ_FIRST, CROSS_FWD=1, no output registers
//   u1: DEPTH=256, A WRITE_FIRST with output register, B READ_FIRST, CROSS_FWD=0
module tb_tdpram_singleclk_bwe;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // u0 signals
    logic        ena0, enb0;
    logic [3:0]  wena0, wenb0;
    logic [6:0]  addra0, addrb0;
    logic [31:0] dina0, dinb0, douta0, doutb0;
    logic        valida0, validb0, coll0;
    // u1 signals
    logic        ena1, enb1;
    logic [3:0]  wena1, wenb1;
    logic [7:0]  addra1, addrb1;
    logic [31:0] dina1, dinb1, douta1, doutb1;
    logic        valida1, validb1, coll1;
`ifdef TDPRAM_COLL_CNT_EN
    logic [15:0] cnt0, cnt1;
`endif

    tdpram_singleclk_bwe #(
        .DEPTH(100), .WRITE_MODE_A("NO_CHANGE"), .WRITE_MODE_B("READ_FIRST"),
        .OUTPUT_REG_A(1'b0), .OUTPUT_REG_B(1'b0), .CROSS_FWD(1'b1), .RAM_INIT_FILE("")
    ) u0 (
        .CLK_I(clk), .RST_N_I(rst_n),
        .ENA_I(ena0), .WENA_I(wena0), .ADDRA_I(addra0), .DINA_I(dina0),
        .DOUTA_O(douta0), .VALIDA_O(valida0),
        .ENB_I(enb0), .WENB_I(wenb0), .ADDRB_I(addrb0), .DINB_I(dinb0),
        .DOUTB_O(doutb0), .VALIDB_O(validb0),
        .COLL_O(coll0)
`ifdef TDPRAM_COLL_CNT_EN
        , .COLL_CNT_O(cnt0)
`endif
    );

    tdpram_singleclk_bwe #(
        .DEPTH(256), .WRITE_MODE_A("WRITE_FIRST"), .WRITE_MODE_B("READ_FIRST"),
        .OUTPUT_REG_A(1'b1), .OUTPUT_REG_B(1'b0), .CROSS_FWD(1'b0), .RAM_INIT_FILE("")
    ) u1 (
        .CLK_I(clk), .RST_N_I(rst_n),
        .ENA_I(ena1), .WENA_I(wena1), .ADDRA_I(addra1), .DINA_I(dina1),
        .DOUTA_O(douta1), .VALIDA_O(valida1),
        .ENB_I(enb1), .WENB_I(wenb1), .ADDRB_I(addrb1), .DINB_I(dinb1),
        .DOUTB_O(doutb1), .VALIDB_O(validb1),
        .COLL_O(coll1)
`ifdef TDPRAM_COLL_CNT_EN
        , .COLL_CNT_O(cnt1)
`endif
    );

    typedef struct {
        logic        ena;
        logic [3:0]  wena;
        logic [6:0]  addra;
        logic [31:0] dina;
        logic        enb;
        logic [3:0]  wenb;
        logic [6:0]  addrb;
        logic [31:0] dinb;
        logic [31:0] exp_douta;
        logic        exp_valida;
        logic [31:0] exp_doutb;
        logic        exp_validb;
        logic        exp_coll;
    } vec_t;

    localparam int NumVec = 20;
    vec_t vecs [NumVec];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    function automatic vec_t mk(input logic ea, input logic [3:0] wa, input logic [6:0] aa,
                                input logic [31:0] da, input logic eb, input logic [3:0] wb,
                                input logic [6:0] ab, input logic [31:0] db,
                                input logic [31:0] xa, input logic va,
                                input logic [31:0] xb, input logic vb, input logic xc);
        vec_t v;
        v.ena = ea; v.wena = wa; v.addra = aa; v.dina = da;
        v.enb = eb; v.wenb = wb; v.addrb = ab; v.dinb = db;
        v.exp_douta = xa; v.exp_valida = va; v.exp_doutb = xb; v.exp_validb = vb;
        v.exp_coll = xc;
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // ------------------------------------------------------------ u0 vectors
        //              ena wena addra dina          enb wenb addrb dinb
        //              | exp_douta     va  exp_doutb      vb  coll
        vecs[0]  = mk(1, 4'hF, 5,   32'h11223344, 0, 4'h0, 0,  32'h0,
                      32'h0,        0, 32'h0,        0, 0);
        vecs[1]  = mk(1, 4'h5, 5,   32'hAABBCCDD, 0, 4'h0, 0,  32'h0,
                      32'h0,        0, 32'h0,        0, 0);
        vecs[2]  = mk(1, 4'h0, 5,   32'h0,        1, 4'h0, 5,  32'h0,
                      32'h11BB33DD, 1, 32'h11BB33DD, 1, 0);
        vecs[3]  = mk(1, 4'hF, 9,   32'h00000000, 0, 4'h0, 0,  32'h0,
                      32'h11BB33DD, 0, 32'h11BB33DD, 0, 0);
        // dual write to addr 9; B's read sees A's lanes 0/1 forwarded
        vecs[4]  = mk(1, 4'h3, 9,   32'h0000FFFF, 1, 4'hF, 9,  32'hEEEE1111,
                      32'h11BB33DD, 0, 32'h0000FFFF, 1, 1);
        vecs[5]  = mk(1, 4'h0, 9,   32'h0,        0, 4'h0, 0,  32'h0,
                      32'hEEEEFFFF, 1, 32'h0000FFFF, 0, 0);
        vecs[6]  = mk(1, 4'hF, 3,   32'h01020304, 0, 4'h0, 0,  32'h0,
                      32'hEEEEFFFF, 0, 32'h0000FFFF, 0, 0);
        vecs[7]  = mk(1, 4'hF, 3,   32'h5A5A5A5A, 1, 4'h0, 3,  32'h0,
                      32'hEEEEFFFF, 0, 32'h5A5A5A5A, 1, 1);
        vecs[8]  = mk(0, 4'h0, 0,   32'h0,        1, 4'h0, 3,  32'h0,
                      32'hEEEEFFFF, 0, 32'h5A5A5A5A, 1, 0);
        vecs[9]  = mk(1, 4'hF, 7,   32'h00001234, 0, 4'h0, 0,  32'h0,
                      32'hEEEEFFFF, 0, 32'h5A5A5A5A, 0, 0);
        vecs[10] = mk(1, 4'h0, 7,   32'h0,        0, 4'h0, 0,  32'h0,
                      32'h00001234, 1, 32'h5A5A5A5A, 0, 0);
        vecs[11] = mk(1, 4'hF, 7,   32'hFFFFFFFF, 0, 4'h0, 0,  32'h0,
                      32'h00001234, 0, 32'h5A5A5A5A, 0, 0);
        vecs[12] = mk(1, 4'h0, 7,   32'h0,        0, 4'h0, 0,  32'h0,
                      32'hFFFFFFFF, 1, 32'h5A5A5A5A, 0, 0);
        vecs[13] = mk(1, 4'hF, 99,  32'hCAFEF00D, 0, 4'h0, 0,  32'h0,
                      32'hFFFFFFFF, 0, 32'h5A5A5A5A, 0, 0);
        vecs[14] = mk(1, 4'hF, 100, 32'hDEADBEEF, 1, 4'h0, 99, 32'h0,
                      32'hFFFFFFFF, 0, 32'hCAFEF00D, 1, 0);
        vecs[15] = mk(1, 4'h0, 100, 32'h0,        1, 4'h0, 99, 32'h0,
                      32'h00000000, 1, 32'hCAFEF00D, 1, 0);
        vecs[16] = mk(0, 4'h0, 0,   32'h0,        1, 4'h0, 100, 32'h0,
                      32'h00000000, 0, 32'h00000000, 1, 0);
        vecs[17] = mk(0, 4'h0, 0,   32'h0,        0, 4'h0, 0,  32'h0,
                      32'h00000000, 0, 32'h00000000, 0, 0);
        // B writes upper lanes of addr 3 while A reads: A sees B's lanes forwarded
        vecs[18] = mk(1, 4'h0, 3,   32'h0,        1, 4'hC, 3,  32'h77660000,
                      32'h77665A5A, 1, 32'h5A5A5A5A, 1, 1);
        vecs[19] = mk(1, 4'h0, 3,   32'h0,        0, 4'h0, 0,  32'h0,
                      32'h77665A5A, 1, 32'h5A5A5A5A, 0, 0);

        ena0 = 0; wena0 = '0; addra0 = '0; dina0 = '0;
        enb0 = 0; wenb0 = '0; addrb0 = '0; dinb0 = '0;
        ena1 = 0; wena1 = '0; addra1 = '0; dina1 = '0;
        enb1 = 0; wenb1 = '0; addrb1 = '0; dinb1 = '0;

        // ------------------------------------------------------------ reset state
        step();
        step();
        check("rst douta0", douta0, 32'h0);
        check("rst valida0", 32'(valida0), 32'h0);
        check("rst coll0", 32'(coll0), 32'h0);
        check("rst douta1", douta1, 32'h0);
        check("rst valida1", 32'(valida1), 32'h0);
`ifdef TDPRAM_COLL_CNT_EN
        check("rst cnt1", 32'(cnt1), 32'h0);
`endif
        rst_n = 1'b1;
        step();

        // ------------------------------------------------------------ u0 table
        for (int i = 0; i < NumVec; i++) begin
            ena0 = vecs[i].ena; wena0 = vecs[i].wena; addra0 = vecs[i].addra;
            dina0 = vecs[i].dina;
            enb0 = vecs[i].enb; wenb0 = vecs[i].wenb; addrb0 = vecs[i].addrb;
            dinb0 = vecs[i].dinb;
            step();
            check($sformatf("v%0d douta", i), douta0, vecs[i].exp_douta);
            check($sformatf("v%0d valida", i), 32'(valida0), 32'(vecs[i].exp_valida));
            check($sformatf("v%0d doutb", i), doutb0, vecs[i].exp_doutb);
            check($sformatf("v%0d validb", i), 32'(validb0), 32'(vecs[i].exp_validb));
            check($sformatf("v%0d coll", i), 32'(coll0), 32'(vecs[i].exp_coll));
        end
        ena0 = 0; enb0 = 0; wena0 = '0; wenb0 = '0;

        // ------------------------------------------------------------ u1: no forwarding
        ena1 = 1; wena1 = 4'hF; addra1 = 8'd3; dina1 = 32'h01020304;
        step();
        check("u1 oreg latency douta", douta1, 32'h0);
        check("u1 oreg latency valida", 32'(valida1), 32'h0);
        dina1 = 32'h5A5A5A5A;
        enb1 = 1; wenb1 = 4'h0; addrb1 = 8'd3;
        step();
        check("u1 wf first douta", douta1, 32'h01020304);
        check("u1 wf first valida", 32'(valida1), 32'h1);
        check("u1 nofwd doutb", doutb1, 32'h01020304);
        check("u1 nofwd validb", 32'(validb1), 32'h1);
        check("u1 coll", 32'(coll1), 32'h1);
        ena1 = 0; enb1 = 0; wena1 = '0;
        step();
        check("u1 wf douta", douta1, 32'h5A5A5A5A);
        check("u1 wf valida", 32'(valida1), 32'h1);
        check("u1 idle validb", 32'(validb1), 32'h0);
        check("u1 coll pulse end", 32'(coll1), 32'h0);
        step();
        check("u1 valid pulse end", 32'(valida1), 32'h0);
        check("u1 hold douta", douta1, 32'h5A5A5A5A);

        // byte-lane write with write-first returns a lane merge
        ena1 = 1; wena1 = 4'hF; addra1 = 8'd5; dina1 = 32'h11223344;
        step();
        wena1 = 4'h5; dina1 = 32'hAABBCCDD;
        step();
        check("u1 full write douta", douta1, 32'h11223344);
        ena1 = 0; wena1 = '0;
        step();
        check("u1 bwe wf douta", douta1, 32'h11BB33DD);
        check("u1 bwe wf valida", 32'(valida1), 32'h1);

        // ------------------------------------------------------------ reset mid-read
        ena1 = 1; wena1 = '0; addra1 = 8'd3;
        step();
        ena1 = 0;
        #2 rst_n = 1'b0;
        #1;
        check("midrst douta", douta1, 32'h0);
        check("midrst valida", 32'(valida1), 32'h0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        step();
        check("post rst valida", 32'(valida1), 32'h0);
        check("post rst douta", douta1, 32'h0);
        step();
        check("post rst valida 2", 32'(valida1), 32'h0);
        ena1 = 1; addra1 = 8'd3;
        step();
        ena1 = 0;
        step();
        check("retained douta", douta1, 32'h5A5A5A5A);
        check("retained valida", 32'(valida1), 32'h1);

`ifdef TDPRAM_COLL_CNT_EN
        // ------------------------------------------------------------ counter saturation
        ena1 = 1; enb1 = 1; wena1 = 4'hF; wenb1 = 4'h0; addra1 = 8'd40; addrb1 = 8'd40;
        step();
        step();
        check("cnt one", 32'(cnt1), 32'h1);
        for (int i = 0; i < 70000; i++) step();
        ena1 = 0; enb1 = 0; wena1 = '0;
        step();
        step();
        check("cnt saturated", 32'(cnt1), 32'h0000FFFF);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
